// File: rtl/vec_mem_bridge.sv
// Memory-stage bridge: splits each 48-bit processor access into three
// 16-bit beats on a synchronous single-port RAM and stalls the pipeline
// while the access is in flight. RAM controls are registered so that they
// line up with the WRITE/READ beat they belong to.
module vec_mem_bridge #(
    parameter int DATA_W = 48,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 16,
    parameter int RAM_AW = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [LANE_W-1:0] ram_wdata,
    input  logic [LANE_W-1:0] ram_rdata
);

    localparam int LANES = DATA_W / LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          beat_r;
    logic [1:0]          beat_s;
    logic                accept_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   asm_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic                rd_valid_r;
    logic                ram_en_r;
    logic                ram_we_r;
    logic [RAM_AW-1:0]   ram_addr_r;
    logic [LANE_W-1:0]   ram_wdata_r;
    logic                ram_en_s;
    logic                ram_we_s;
    logic [RAM_AW-1:0]   ram_addr_s;
    logic [LANE_W-1:0]   ram_wdata_s;
    logic [ADDR_W-1:0]   addr_src_s;
    logic [DATA_W-1:0]   wdata_src_s;

    // Word address times three, widened first so the top word cannot wrap.
    function automatic logic [RAM_AW-1:0] base_of(input logic [ADDR_W-1:0] a);
        logic [RAM_AW-1:0] ext;
        ext = {{(RAM_AW-ADDR_W){1'b0}}, a};
        return (ext << 1) + ext;
    endfunction

    // Lane k of a processor word; beat value 3 never carries write data.
    function automatic logic [LANE_W-1:0] lane_of(input logic [DATA_W-1:0] w,
                                                  input logic [1:0]        idx);
        logic [LANE_W-1:0] l;
        case (idx)
            2'd0:    l = w[0*LANE_W +: LANE_W];
            2'd1:    l = w[1*LANE_W +: LANE_W];
            2'd2:    l = w[(LANES-1)*LANE_W +: LANE_W];
            default: l = {LANE_W{1'b0}};
        endcase
        return l;
    endfunction

    // Next-state and beat sequencing; accept only from IDLE.
    always_comb begin
        state_s  = state_r;
        beat_s   = beat_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    beat_s   = 2'd0;
                    state_s  = req_we ? WRITE : READ;
                end else begin
                    state_s  = IDLE;
                end
            end
            WRITE: begin
                if (beat_r == 2'd2) begin
                    state_s = DONE;
                    beat_s  = 2'd0;
                end else begin
                    beat_s  = beat_r + 2'd1;
                end
            end
            READ: begin
                if (beat_r == 2'd3) begin
                    state_s = DONE;
                    beat_s  = 2'd0;
                end else begin
                    beat_s  = beat_r + 2'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
                beat_s  = 2'd0;
            end
            default: begin
                state_s = IDLE;
                beat_s  = 2'd0;
            end
        endcase
    end

    // RAM controls for the upcoming beat; live request only on the accept edge.
    always_comb begin
        addr_src_s  = accept_s ? req_addr  : addr_r;
        wdata_src_s = accept_s ? req_wdata : wdata_r;
        ram_en_s    = (state_s == WRITE) || ((state_s == READ) && (beat_s != 2'd3));
        ram_we_s    = (state_s == WRITE);
        if (ram_en_s) begin
            ram_addr_s = base_of(addr_src_s) + {{(RAM_AW-2){1'b0}}, beat_s};
        end else begin
            ram_addr_s = {RAM_AW{1'b0}};
        end
        if (ram_we_s) begin
            ram_wdata_s = lane_of(wdata_src_s, beat_s);
        end else begin
            ram_wdata_s = {LANE_W{1'b0}};
        end
    end

    // State, beat and RAM control registers; reset drops RAM controls at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            beat_r      <= 2'd0;
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {RAM_AW{1'b0}};
            ram_wdata_r <= {LANE_W{1'b0}};
        end else begin
            state_r     <= state_s;
            beat_r      <= beat_s;
            ram_en_r    <= ram_en_s;
            ram_we_r    <= ram_we_s;
            ram_addr_r  <= ram_addr_s;
            ram_wdata_r <= ram_wdata_s;
        end
    end

    // Request capture; later beats never look at the live inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Read assembly: lanes shift in from the top on beats 1..3, word lands in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_r      <= {DATA_W{1'b0}};
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= (state_r == READ) && (beat_r == 2'd3);
            if ((state_r == READ) && (beat_r != 2'd0)) begin
                asm_r <= {ram_rdata, asm_r[DATA_W-1:LANE_W]};
            end else begin
                asm_r <= asm_r;
            end
            if ((state_r == READ) && (beat_r == 2'd3)) begin
                rd_data_r <= {ram_rdata, asm_r[DATA_W-1:LANE_W]};
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign stall     = ((state_r == IDLE) && req_valid) || (state_r == WRITE) || (state_r == READ);
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign ram_en    = ram_en_r;
    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_vec_mem_bridge.sv
// Directed bench for vec_mem_bridge with a behavioural synchronous RAM.
module tb_vec_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [47:0] req_wdata = 48'h0;
    logic        stall;
    logic [47:0] rd_data;
    logic        rd_valid;
    logic        ram_en;
    logic        ram_we;
    logic [17:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0000;

    logic [15:0] mem [0:262143];

    int          checks = 0;
    int          errors = 0;
    logic [47:0] last_rd = 48'h0;

    vec_mem_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears one cycle after an enabled read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic do_store(input string name, input logic [15:0] a, input logic [47:0] d,
                            input logic [17:0] base, input bit flush);
        logic [36:0] e;
        logic [49:0] e2;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        #1;
        e = {1'b1, 1'b0, 1'b0, 18'h0, 16'h0};
        checks++;
        if ({stall, ram_en, ram_we, ram_addr, ram_wdata} !== e) begin
            errors++;
            $display("FAIL %s_idle got=%h want=%h", name, {stall, ram_en, ram_we, ram_addr, ram_wdata}, e);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (flush) begin
                req_valid = 1'b0; req_we = 1'b0; req_addr = a ^ 16'h1234; req_wdata = ~d;
            end
            #1;
            e = {1'b1, 1'b1, 1'b1, base + 18'(k), d[16*k +: 16]};
            checks++;
            if ({stall, ram_en, ram_we, ram_addr, ram_wdata} !== e) begin
                errors++;
                $display("FAIL %s_beat%0d got=%h want=%h", name, k, {stall, ram_en, ram_we, ram_addr, ram_wdata}, e);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        e2 = {1'b0, 1'b0, 1'b0, last_rd};
        checks++;
        if ({stall, ram_en, rd_valid, rd_data} !== e2) begin
            errors++;
            $display("FAIL %s_done got=%h want=%h", name, {stall, ram_en, rd_valid, rd_data}, e2);
        end
    endtask

    task automatic do_load(input string name, input logic [15:0] a, input logic [17:0] base,
                           input logic [47:0] expd);
        logic [20:0] e;
        logic [49:0] e2;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 48'h0;
        #1;
        e = {1'b1, 1'b0, 1'b0, 18'h0};
        checks++;
        if ({stall, ram_en, ram_we, ram_addr} !== e) begin
            errors++;
            $display("FAIL %s_idle got=%h want=%h", name, {stall, ram_en, ram_we, ram_addr}, e);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            e = {1'b1, 1'b1, 1'b0, base + 18'(k)};
            checks++;
            if ({stall, ram_en, ram_we, ram_addr} !== e) begin
                errors++;
                $display("FAIL %s_beat%0d got=%h want=%h", name, k, {stall, ram_en, ram_we, ram_addr}, e);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({stall, ram_en, rd_valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s_beat3 got=%b want=100", name, {stall, ram_en, rd_valid});
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        e2 = {1'b0, 1'b0, 1'b1, expd};
        checks++;
        if ({stall, ram_en, rd_valid, rd_data} !== e2) begin
            errors++;
            $display("FAIL %s_done got=%h want=%h", name, {stall, ram_en, rd_valid, rd_data}, e2);
        end
        last_rd = expd;
        @(negedge clk); #1;
        e2 = {1'b0, 1'b0, 1'b0, expd};
        checks++;
        if ({stall, ram_en, rd_valid, rd_data} !== e2) begin
            errors++;
            $display("FAIL %s_hold got=%h want=%h", name, {stall, ram_en, rd_valid, rd_data}, e2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0001;
        req_wdata = 48'h0000_0000_0000;
        @(negedge clk); #1;
        checks++;
        if ({stall, ram_en, ram_we, rd_valid, rd_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 48'h0}) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", {stall, ram_en, ram_we, rd_valid, rd_data},
                     {1'b1, 1'b0, 1'b0, 1'b0, 48'h0});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({stall, ram_en} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got=%b want=10", {stall, ram_en});
        end
        @(negedge clk); #1;
        checks++;
        if ({stall, ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b1, 18'h00003}) begin
            errors++;
            $display("FAIL reset_accept got=%h want=%h", {stall, ram_en, ram_we, ram_addr},
                     {1'b1, 1'b1, 1'b1, 18'h00003});
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        do_store("store", 16'h0002, 48'hAAAA_BBBB_CCCC, 18'h00006, 1'b0);
    endtask

    task automatic test_load();
        do_load("load", 16'h0002, 18'h00006, 48'hAAAA_BBBB_CCCC);
    endtask

    task automatic test_boundary();
        do_store("bnd_store", 16'hFFFF, 48'h1234_5678_9ABC, 18'h2FFFD, 1'b0);
        do_load("bnd_load", 16'hFFFF, 18'h2FFFD, 48'h1234_5678_9ABC);
    endtask

    task automatic test_flush();
        do_store("flush", 16'h0005, 48'h0F0F_F0F0_5A5A, 18'h0000F, 1'b1);
        @(negedge clk); #1;
        checks++;
        if ({stall, ram_en, rd_valid} !== 3'b000) begin
            errors++;
            $display("FAIL flush_idle got=%b want=000", {stall, ram_en, rd_valid});
        end
        do_load("flush_load", 16'h0005, 18'h0000F, 48'h0F0F_F0F0_5A5A);
    endtask

    task automatic test_reset_mid_write();
        do_store("pre", 16'h0010, 48'h1111_2222_3333, 18'h00030, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 48'h4444_5555_6666;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({ram_en, ram_we, rd_data} !== {1'b0, 1'b0, 48'h0}) begin
            errors++;
            $display("FAIL midrst_abort got=%h want=%h", {ram_en, ram_we, rd_data}, {1'b0, 1'b0, 48'h0});
        end
        last_rd = 48'h0;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        do_load("midrst_load", 16'h0010, 18'h00030, 48'h1111_2222_6666);
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_boundary();
        test_flush();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
